// File: rtl/render_pkg.sv
// Shared types for the sprite pass sequencer: tile geometry, FSM encoding and
// the sprite table entry layout.
package render_pkg;

    localparam int         TILE_W      = 16;
    localparam logic [7:0] TRANSPARENT = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SCAN     = 3'd1,
        ST_FETCH    = 3'd2,
        ST_ISSUE    = 3'd3,
        ST_BG_FETCH = 3'd4,
        ST_BG_ISSUE = 3'd5,
        ST_OUT      = 3'd6
    } state_t;

    // 33-bit table entry; z == 0 marks the entry disabled.
    typedef struct packed {
        logic [8:0] x;
        logic [7:0] y;
        logic [7:0] z;
        logic [7:0] tex;
    } spr_entry_t;

endpackage

// File: rtl/sprite_pass_sequencer_if.sv
// Texture row fetch channel between the sequencer (master) and texture memory (slave).
// Handshake: fetch_req stays high with fetch_addr stable until the cycle fetch_ack is
// high; that cycle transfers fetch_data and completes the request.
interface sprite_pass_sequencer_if;

    logic         fetch_req;
    logic [11:0]  fetch_addr;
    logic         fetch_ack;
    logic [127:0] fetch_data;

    modport master (output fetch_req, fetch_addr, input fetch_ack, fetch_data);
    modport slave  (input fetch_req, fetch_addr, output fetch_ack, fetch_data);

endinterface

// File: rtl/sprite_table.sv
// Sprite table register file: one synchronous write port, one asynchronous read port.
// A read in the write cycle returns the pre-write entry.
module sprite_table
    import render_pkg::*;
#(
    parameter int SPRITE_COUNT = 8,
    parameter int SW           = $clog2(SPRITE_COUNT)
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       we_i,
    input  logic [SW-1:0] waddr_i,
    input  spr_entry_t wdata_i,
    input  logic [SW-1:0] raddr_i,
    output spr_entry_t rdata_o
);

    spr_entry_t mem_q [SPRITE_COUNT];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SPRITE_COUNT; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sprite_pass_sequencer.sv
// Walks the frame tile by tile, issuing one StreamProcessor pass per sprite hit
// followed by a background pass, then presents the finished tile to the consumer.
module sprite_pass_sequencer
    import render_pkg::*;
#(
    parameter int SPRITE_COUNT = 8,
    parameter int LINE_TILES   = 20,
    parameter int LINES        = 240,
    parameter int SW           = $clog2(SPRITE_COUNT)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          i_frame_start,
    input  logic          i_spr_we,
    input  logic [SW-1:0] i_spr_addr,
    input  logic [8:0]    i_spr_x,
    input  logic [7:0]    i_spr_y,
    input  logic [7:0]    i_spr_z,
    input  logic [7:0]    i_spr_tex,
    input  logic [7:0]    i_bg_tex,
    sprite_pass_sequencer_if.master fetch,
    output logic          o_sp_ena,
    output logic [127:0]  o_texture_data,
    output logic [4:0]    o_start_x,
    output logic [7:0]    o_position_z,
    output logic          o_tile_valid,
    input  logic          i_tile_ready,
    output logic [4:0]    o_tile_x,
    output logic [7:0]    o_line_y,
    output logic          o_busy,
    output state_t        o_state
);

    state_t        state_q;
    logic [SW-1:0] idx_q;
    logic [4:0]    tile_q;
    logic [7:0]    line_q;
    logic [7:0]    bg_tex_q;
    logic          busy_q;
    logic          fetch_req_q;
    logic [11:0]   fetch_addr_q;
    logic          sp_ena_q;
    logic [127:0]  tex_data_q;
    logic [4:0]    start_x_q;
    logic [7:0]    pos_z_q;
    logic          tile_valid_q;
    logic [4:0]    hit_sx_q;
    logic [7:0]    hit_z_q;

    spr_entry_t        wr_ent;
    spr_entry_t        ent;
    logic [8:0]        dy_w;
    logic [9:0]        tile_px_w;
    logic signed [9:0] dx_w;
    logic              hit_w;
    logic              last_idx_w;
    logic              last_tile_w;
    logic              last_line_w;

    assign wr_ent = '{x: i_spr_x, y: i_spr_y, z: i_spr_z, tex: i_spr_tex};

    sprite_table #(
        .SPRITE_COUNT (SPRITE_COUNT),
        .SW           (SW)
    ) u_table (
        .clk     (clk),
        .reset_n (reset_n),
        .we_i    (i_spr_we),
        .waddr_i (i_spr_addr),
        .wdata_i (wr_ent),
        .raddr_i (idx_q),
        .rdata_o (ent)
    );

    // A borrow in dy means the sprite starts below this line; it must not wrap into a hit.
    assign dy_w      = {1'b0, line_q} - {1'b0, ent.y};
    assign tile_px_w = 10'(tile_q) * 10'(TILE_W);
    assign dx_w      = $signed({1'b0, ent.x}) - $signed(tile_px_w);
    assign hit_w     = (ent.z != 8'd0) && !dy_w[8] && (dy_w[7:4] == 4'd0)
                       && (dx_w >= -10'sd15) && (dx_w <= 10'sd15);

    assign last_idx_w  = (idx_q == SW'(SPRITE_COUNT - 1));
    assign last_tile_w = (tile_q == 5'(LINE_TILES - 1));
    assign last_line_w = (line_q == 8'(LINES - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            tile_q       <= '0;
            line_q       <= '0;
            bg_tex_q     <= '0;
            busy_q       <= 1'b0;
            fetch_req_q  <= 1'b0;
            fetch_addr_q <= '0;
            sp_ena_q     <= 1'b0;
            tex_data_q   <= '0;
            start_x_q    <= '0;
            pos_z_q      <= '0;
            tile_valid_q <= 1'b0;
            hit_sx_q     <= '0;
            hit_z_q      <= '0;
        end else begin
            sp_ena_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (i_frame_start) begin
                        tile_q   <= '0;
                        line_q   <= '0;
                        bg_tex_q <= i_bg_tex;
                        busy_q   <= 1'b1;
                        idx_q    <= '0;
                        state_q  <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (hit_w) begin
                        fetch_req_q  <= 1'b1;
                        fetch_addr_q <= {ent.tex, dy_w[3:0]};
                        hit_sx_q     <= dx_w[4:0] + 5'd16;
                        hit_z_q      <= ent.z;
                        state_q      <= ST_FETCH;
                    end else if (last_idx_w) begin
                        fetch_req_q  <= 1'b1;
                        fetch_addr_q <= {bg_tex_q, line_q[3:0]};
                        state_q      <= ST_BG_FETCH;
                    end else begin
                        idx_q <= idx_q + SW'(1);
                    end
                end
                ST_FETCH: begin
                    if (fetch.fetch_ack) begin
                        fetch_req_q <= 1'b0;
                        tex_data_q  <= fetch.fetch_data;
                        sp_ena_q    <= 1'b1;
                        start_x_q   <= hit_sx_q;
                        pos_z_q     <= hit_z_q;
                        state_q     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (last_idx_w) begin
                        fetch_req_q  <= 1'b1;
                        fetch_addr_q <= {bg_tex_q, line_q[3:0]};
                        state_q      <= ST_BG_FETCH;
                    end else begin
                        idx_q   <= idx_q + SW'(1);
                        state_q <= ST_SCAN;
                    end
                end
                ST_BG_FETCH: begin
                    if (fetch.fetch_ack) begin
                        fetch_req_q <= 1'b0;
                        tex_data_q  <= fetch.fetch_data;
                        sp_ena_q    <= 1'b1;
                        start_x_q   <= 5'(TILE_W);
                        pos_z_q     <= 8'd0;
                        state_q     <= ST_BG_ISSUE;
                    end
                end
                ST_BG_ISSUE: begin
                    tile_valid_q <= 1'b1;
                    state_q      <= ST_OUT;
                end
                ST_OUT: begin
                    if (i_tile_ready) begin
                        tile_valid_q <= 1'b0;
                        idx_q        <= '0;
                        if (!last_tile_w) begin
                            tile_q  <= tile_q + 5'd1;
                            state_q <= ST_SCAN;
                        end else if (!last_line_w) begin
                            tile_q  <= '0;
                            line_q  <= line_q + 8'd1;
                            state_q <= ST_SCAN;
                        end else begin
                            tile_q  <= '0;
                            line_q  <= '0;
                            busy_q  <= 1'b0;
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign fetch.fetch_req  = fetch_req_q;
    assign fetch.fetch_addr = fetch_addr_q;
    assign o_sp_ena         = sp_ena_q;
    assign o_texture_data   = tex_data_q;
    assign o_start_x        = start_x_q;
    assign o_position_z     = pos_z_q;
    assign o_tile_valid     = tile_valid_q;
    assign o_tile_x         = tile_q;
    assign o_line_y         = line_q;
    assign o_busy           = busy_q;
    assign o_state          = state_q;

endmodule

// File: tb/tb_sprite_pass_sequencer.sv
// Directed bench for sprite_pass_sequencer: a texture memory responder with
// programmable ack delay, a pass-strobe monitor, and one task per scenario.
module tb_sprite_pass_sequencer;
    import render_pkg::*;

    localparam int SW = 3;
    localparam logic [127:0] JUNK = {32{4'h3}};

    // clock / reset
    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    logic          frame_start = 1'b0;
    logic          spr_we = 1'b0;
    logic [SW-1:0] spr_addr = '0;
    logic [8:0]    spr_x = '0;
    logic [7:0]    spr_y = '0;
    logic [7:0]    spr_z = '0;
    logic [7:0]    spr_tex = '0;
    logic [7:0]    bg_tex = '0;
    logic          tile_ready = 1'b0;

    logic          sp_ena;
    logic [127:0]  tex_data;
    logic [4:0]    start_x;
    logic [7:0]    pos_z;
    logic          tile_valid;
    logic [4:0]    tile_x;
    logic [7:0]    line_y;
    logic          busy;
    state_t        dut_state;

    sprite_pass_sequencer_if fbus();

    sprite_pass_sequencer dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .i_frame_start  (frame_start),
        .i_spr_we       (spr_we),
        .i_spr_addr     (spr_addr),
        .i_spr_x        (spr_x),
        .i_spr_y        (spr_y),
        .i_spr_z        (spr_z),
        .i_spr_tex      (spr_tex),
        .i_bg_tex       (bg_tex),
        .fetch          (fbus.master),
        .o_sp_ena       (sp_ena),
        .o_texture_data (tex_data),
        .o_start_x      (start_x),
        .o_position_z   (pos_z),
        .o_tile_valid   (tile_valid),
        .i_tile_ready   (tile_ready),
        .o_tile_x       (tile_x),
        .o_line_y       (line_y),
        .o_busy         (busy),
        .o_state        (dut_state)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [7:0]   line;
        logic [4:0]   tile;
        logic [4:0]   sx;
        logic [7:0]   z;
        logic [127:0] tex;
    } ev_t;

    ev_t         obs_q[$];
    logic [11:0] fetch_q[$];
    logic [25:0] exp_q[$];
    logic [11:0] exp_addr_q[$];

    bit auto_ack  = 1'b1;
    int ack_delay = 0;
    int req_cnt   = 0;

    function automatic logic [127:0] pat(input logic [11:0] a);
        return {8{a, 4'hA}};
    endfunction

    // texture memory responder: acks after ack_delay waiting cycles
    initial begin
        fbus.fetch_ack  = 1'b0;
        fbus.fetch_data = JUNK;
        forever begin
            @(negedge clk);
            if (auto_ack && fbus.fetch_req) begin
                if (req_cnt >= ack_delay) begin
                    fbus.fetch_ack  = 1'b1;
                    fbus.fetch_data = pat(fbus.fetch_addr);
                    fetch_q.push_back(fbus.fetch_addr);
                    req_cnt = 0;
                end else begin
                    fbus.fetch_ack  = 1'b0;
                    fbus.fetch_data = JUNK;
                    req_cnt++;
                end
            end else begin
                fbus.fetch_ack  = 1'b0;
                fbus.fetch_data = JUNK;
                req_cnt = 0;
            end
        end
    end

    // pass strobe monitor
    initial begin
        ev_t e;
        forever begin
            @(negedge clk);
            if (sp_ena) begin
                e.line = line_y; e.tile = tile_x; e.sx = start_x; e.z = pos_z; e.tex = tex_data;
                obs_q.push_back(e);
                n_checks++;
                if (dut_state != ST_ISSUE && dut_state != ST_BG_ISSUE) begin
                    n_fail++; $display("FAIL ena_state: ena seen in state %0d, expected ISSUE or BG_ISSUE", dut_state);
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // driver tasks
    task automatic do_reset();
        reset_n = 1'b0; frame_start = 1'b0; spr_we = 1'b0; tile_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic write_spr(input logic [SW-1:0] a, input logic [8:0] x,
                             input logic [7:0] y, input logic [7:0] z, input logic [7:0] t);
        spr_we = 1'b1; spr_addr = a; spr_x = x; spr_y = y; spr_z = z; spr_tex = t;
        @(negedge clk);
        spr_we = 1'b0;
    endtask

    task automatic pulse_frame(input logic [7:0] bg);
        bg_tex = bg; frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic clear_queues();
        obs_q.delete(); fetch_q.delete(); exp_q.delete(); exp_addr_q.delete();
    endtask

    task automatic wait_tile();
        bit ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (tile_valid) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL tile_timeout: tile_valid got 0 expected 1 within 300 cycles"); end
    endtask

    task automatic accept_tile();
        tile_ready = 1'b1;
        @(negedge clk);
        tile_ready = 1'b0;
    endtask

    // scenarios
    task automatic test_reset();
        #1 reset_n = 1'b0;
        @(negedge clk);
        n_checks++; if (fbus.fetch_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %0b expected 0", fbus.fetch_req); end
        n_checks++; if (sp_ena !== 1'b0) begin n_fail++; $display("FAIL rst_ena: got %0b expected 0", sp_ena); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %0b expected 0", busy); end
        n_checks++; if (tile_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %0b expected 0", tile_valid); end
        n_checks++; if ({tile_x, line_y, start_x, pos_z} !== 26'd0) begin n_fail++; $display("FAIL rst_coords: got %0h expected 0", {tile_x, line_y, start_x, pos_z}); end
        n_checks++; if (tex_data !== 128'd0) begin n_fail++; $display("FAIL rst_tex: got %0h expected 0", tex_data); end
        reset_n = 1'b1;
        @(negedge clk);
        n_checks++; if (dut_state !== ST_IDLE) begin n_fail++; $display("FAIL rst_state: got %0d expected %0d", dut_state, ST_IDLE); end
    endtask

    task automatic test_reset_mid_fetch();
        bit seen = 1'b0;
        do_reset();
        write_spr(0, 9'd0, 8'd0, 8'd1, 8'h05);
        auto_ack = 1'b0;
        pulse_frame(8'h10);
        for (int i = 0; i < 20; i++) begin
            if (fbus.fetch_req) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        n_checks++; if (!seen) begin n_fail++; $display("FAIL mid_req_seen: got 0 expected 1"); end
        n_checks++; if (fbus.fetch_addr !== 12'h050) begin n_fail++; $display("FAIL mid_addr: got %0h expected 050", fbus.fetch_addr); end
        n_checks++; if (dut_state !== ST_FETCH) begin n_fail++; $display("FAIL mid_state: got %0d expected %0d", dut_state, ST_FETCH); end
        #2 reset_n = 1'b0;
        #1;
        n_checks++; if (fbus.fetch_req !== 1'b0) begin n_fail++; $display("FAIL mid_rst_req: got %0b expected 0", fbus.fetch_req); end
        n_checks++; if (sp_ena !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ena: got %0b expected 0", sp_ena); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy: got %0b expected 0", busy); end
        @(negedge clk);
        reset_n = 1'b1;
        auto_ack = 1'b1;
        @(negedge clk);
        n_checks++; if (dut_state !== ST_IDLE) begin n_fail++; $display("FAIL mid_post_state: got %0d expected %0d", dut_state, ST_IDLE); end
        n_checks++; if (fbus.fetch_req !== 1'b0) begin n_fail++; $display("FAIL mid_post_req: got %0b expected 0", fbus.fetch_req); end
    endtask

    task automatic test_single_sprite();
        do_reset();
        write_spr(0, 9'd20, 8'd5, 8'd3, 8'h07);
        pulse_frame(8'h3C);
        for (int i = 0; i < 101; i++) begin
            wait_tile();
            accept_tile();
        end
        clear_queues();
        wait_tile();
        n_checks++; if ({line_y, tile_x} !== {8'd5, 5'd1}) begin n_fail++; $display("FAIL single_pos: got line %0d tile %0d expected line 5 tile 1", line_y, tile_x); end
        n_checks++; if (fetch_q.size() != 2) begin n_fail++; $display("FAIL single_nfetch: got %0d expected 2", fetch_q.size()); end
        else begin
            n_checks++; if (fetch_q[0] !== 12'h070) begin n_fail++; $display("FAIL single_fetch0: got %0h expected 070", fetch_q[0]); end
            n_checks++; if (fetch_q[1] !== 12'h3C5) begin n_fail++; $display("FAIL single_fetch1: got %0h expected 3c5", fetch_q[1]); end
        end
        n_checks++; if (obs_q.size() != 2) begin n_fail++; $display("FAIL single_nena: got %0d expected 2", obs_q.size()); end
        else begin
            n_checks++; if ({obs_q[0].sx, obs_q[0].z} !== {5'd20, 8'd3}) begin n_fail++; $display("FAIL single_ena0: got sx %0d z %0d expected sx 20 z 3", obs_q[0].sx, obs_q[0].z); end
            n_checks++; if (obs_q[0].tex !== pat(12'h070)) begin n_fail++; $display("FAIL single_tex0: got %0h expected %0h", obs_q[0].tex, pat(12'h070)); end
            n_checks++; if ({obs_q[1].sx, obs_q[1].z} !== {5'd16, 8'd0}) begin n_fail++; $display("FAIL single_ena1: got sx %0d z %0d expected sx 16 z 0", obs_q[1].sx, obs_q[1].z); end
            n_checks++; if (obs_q[1].tex !== pat(12'h3C5)) begin n_fail++; $display("FAIL single_tex1: got %0h expected %0h", obs_q[1].tex, pat(12'h3C5)); end
        end
    endtask

    task automatic test_tile_sweep();
        do_reset();
        write_spr(0, 9'd8, 8'd0, 8'd2, 8'h11);
        write_spr(2, 9'd16, 8'd0, 8'd9, 8'h33);
        clear_queues();
        // {line, tile, start_x, z} with the texture row fetched for that pass
        exp_q.push_back({8'd0, 5'd0, 5'd24, 8'd2}); exp_addr_q.push_back(12'h110);
        exp_q.push_back({8'd0, 5'd0, 5'd16, 8'd0}); exp_addr_q.push_back(12'h200);
        exp_q.push_back({8'd0, 5'd1, 5'd8,  8'd2}); exp_addr_q.push_back(12'h110);
        exp_q.push_back({8'd0, 5'd1, 5'd16, 8'd9}); exp_addr_q.push_back(12'h330);
        exp_q.push_back({8'd0, 5'd1, 5'd16, 8'd0}); exp_addr_q.push_back(12'h200);
        exp_q.push_back({8'd0, 5'd2, 5'd16, 8'd0}); exp_addr_q.push_back(12'h200);
        pulse_frame(8'h20);
        wait_tile(); accept_tile();
        wait_tile(); accept_tile();
        wait_tile();
        n_checks++; if (tile_x !== 5'd2) begin n_fail++; $display("FAIL sweep_tile: got %0d expected 2", tile_x); end
        n_checks++; if (obs_q.size() != exp_q.size() || fetch_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL sweep_count: got %0d passes %0d fetches expected %0d", obs_q.size(), fetch_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_checks++; if ({obs_q[i].line, obs_q[i].tile, obs_q[i].sx, obs_q[i].z} !== exp_q[i]) begin
                    n_fail++; $display("FAIL sweep_pass%0d: got %0h expected %0h", i, {obs_q[i].line, obs_q[i].tile, obs_q[i].sx, obs_q[i].z}, exp_q[i]);
                end
                n_checks++; if (fetch_q[i] !== exp_addr_q[i]) begin n_fail++; $display("FAIL sweep_fetch%0d: got %0h expected %0h", i, fetch_q[i], exp_addr_q[i]); end
                n_checks++; if (obs_q[i].tex !== pat(exp_addr_q[i])) begin n_fail++; $display("FAIL sweep_tex%0d: got %0h expected %0h", i, obs_q[i].tex, pat(exp_addr_q[i])); end
            end
        end
    endtask

    task automatic test_miss_timing();
        int scan_cnt = 0;
        int busy_cnt = 0;
        do_reset();
        write_spr(3, 9'd0, 8'd100, 8'd5, 8'h44);
        clear_queues();
        pulse_frame(8'h55);
        for (int i = 0; i < 100; i++) begin
            if (tile_valid) break;
            if (dut_state == ST_SCAN) scan_cnt++;
            busy_cnt++;
            @(negedge clk);
        end
        n_checks++; if (tile_valid !== 1'b1) begin n_fail++; $display("FAIL miss_valid: got %0b expected 1", tile_valid); end
        n_checks++; if (scan_cnt != 8) begin n_fail++; $display("FAIL miss_scan_cycles: got %0d expected 8", scan_cnt); end
        n_checks++; if (busy_cnt != 10) begin n_fail++; $display("FAIL miss_tile_cycles: got %0d expected 10", busy_cnt); end
        n_checks++; if (obs_q.size() != 1) begin n_fail++; $display("FAIL miss_nena: got %0d expected 1", obs_q.size()); end
        else begin
            n_checks++; if ({obs_q[0].sx, obs_q[0].z} !== {5'd16, 8'd0}) begin n_fail++; $display("FAIL miss_bg: got sx %0d z %0d expected sx 16 z 0", obs_q[0].sx, obs_q[0].z); end
        end
        n_checks++; if (fetch_q.size() != 1 || fetch_q[0] !== 12'h550) begin n_fail++; $display("FAIL miss_fetch: got %0d fetches expected one at 550", fetch_q.size()); end
    endtask

    task automatic test_fetch_stall();
        bit seen = 1'b0;
        do_reset();
        write_spr(0, 9'd0, 8'd0, 8'd4, 8'h22);
        ack_delay = 5;
        clear_queues();
        pulse_frame(8'h66);
        for (int i = 0; i < 20; i++) begin
            if (fbus.fetch_req) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        n_checks++; if (!seen) begin n_fail++; $display("FAIL stall_req_seen: got 0 expected 1"); end
        for (int k = 0; k < 6; k++) begin
            n_checks++; if (fbus.fetch_req !== 1'b1 || fbus.fetch_addr !== 12'h220) begin
                n_fail++; $display("FAIL stall_hold%0d: got req %0b addr %0h expected req 1 addr 220", k, fbus.fetch_req, fbus.fetch_addr);
            end
            n_checks++; if (tex_data !== 128'd0) begin n_fail++; $display("FAIL stall_tex%0d: got %0h expected 0", k, tex_data); end
            if (k < 5) @(negedge clk);
        end
        @(negedge clk);
        n_checks++; if (sp_ena !== 1'b1) begin n_fail++; $display("FAIL stall_ena: got %0b expected 1", sp_ena); end
        n_checks++; if (tex_data !== pat(12'h220)) begin n_fail++; $display("FAIL stall_capture: got %0h expected %0h", tex_data, pat(12'h220)); end
        n_checks++; if ({start_x, pos_z} !== {5'd16, 8'd4}) begin n_fail++; $display("FAIL stall_pass: got sx %0d z %0d expected sx 16 z 4", start_x, pos_z); end
        n_checks++; if (fbus.fetch_req !== 1'b0) begin n_fail++; $display("FAIL stall_req_drop: got %0b expected 0", fbus.fetch_req); end
        wait_tile();
        ack_delay = 0;
        n_checks++; if (obs_q.size() != 2) begin n_fail++; $display("FAIL stall_nena: got %0d expected 2", obs_q.size()); end
    endtask

    task automatic test_backpressure_frame_end();
        int hs = 0;
        logic [4:0] last_x = '0;
        logic [7:0] last_y = '0;
        do_reset();
        clear_queues();
        pulse_frame(8'h77);
        wait_tile();
        for (int k = 0; k < 10; k++) begin
            frame_start = (k == 3);
            n_checks++; if (tile_valid !== 1'b1 || fbus.fetch_req !== 1'b0 || tile_x !== 5'd0) begin
                n_fail++; $display("FAIL bp_hold%0d: got valid %0b req %0b tile %0d expected valid 1 req 0 tile 0", k, tile_valid, fbus.fetch_req, tile_x);
            end
            @(negedge clk);
        end
        frame_start = 1'b0;
        n_checks++; if (dut_state !== ST_OUT || busy !== 1'b1) begin n_fail++; $display("FAIL bp_state: got state %0d busy %0b expected state %0d busy 1", dut_state, busy, ST_OUT); end
        tile_ready = 1'b1;
        for (int i = 0; i < 60000; i++) begin
            if (!busy) break;
            if (tile_valid) begin hs++; last_x = tile_x; last_y = line_y; end
            @(negedge clk);
        end
        tile_ready = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL frame_done: busy got %0b expected 0", busy); end
        n_checks++; if (hs != 4800) begin n_fail++; $display("FAIL frame_tiles: got %0d expected 4800", hs); end
        n_checks++; if ({last_y, last_x} !== {8'd239, 5'd19}) begin n_fail++; $display("FAIL frame_last: got line %0d tile %0d expected line 239 tile 19", last_y, last_x); end
        n_checks++; if (dut_state !== ST_IDLE) begin n_fail++; $display("FAIL frame_idle: got %0d expected %0d", dut_state, ST_IDLE); end
        pulse_frame(8'h01);
        n_checks++; if (busy !== 1'b1 || dut_state !== ST_SCAN) begin n_fail++; $display("FAIL restart: got busy %0b state %0d expected busy 1 state %0d", busy, dut_state, ST_SCAN); end
        n_checks++; if ({line_y, tile_x} !== 13'd0) begin n_fail++; $display("FAIL restart_pos: got line %0d tile %0d expected 0 0", line_y, tile_x); end
    endtask

    initial begin
        test_reset();
        test_reset_mid_fetch();
        test_single_sprite();
        test_tile_sweep();
        test_miss_timing();
        test_fetch_stall();
        test_backpressure_frame_end();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
